// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: op encodings,
// default widths and FSM states.
package calc_pkg;

    localparam int DEF_DIN_W = 16;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_OPS_W = 16;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_ADDN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/calc_sequencer.sv
// Command sequencer for the calculator accumulator: takes one op at a time,
// issues clear/load/add strobes and returns the accumulator value with a sticky carry flag.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIN_W = DEF_DIN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int OPS_W = DEF_OPS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIN_W-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             acc_clear,
    output logic             acc_load,
    output logic             acc_add,
    output logic [DIN_W-1:0] acc_din,
    input  logic [ACC_W-1:0] acc_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ACC_W-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic [OPS_W-1:0] ops_done
);

    state_e             state;
    state_e             state_nxt;
    op_e                op_q;
    logic [DIN_W-1:0]   data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [OPS_W-1:0]   ops_q;

    logic               accept;
    logic               rsp_fire;
    logic               in_exec;
    logic               exec_last;
    logic               exec_clear;
    logic [ACC_W:0]     sum;

    assign accept   = cmd_valid & cmd_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign in_exec  = (state == ST_EXEC) && !rst;

    // ADDN with count 0 or 1 spends exactly one cycle in EXEC.
    assign exec_last = (op_q != OP_ADDN) || (cnt_q <= CNT_W'(1));

    // Carry-out of the add the accumulator performs this cycle.
    assign sum = {1'b0, acc_result} + {{(ACC_W + 1 - DIN_W){1'b0}}, acc_din};

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)    state_nxt = ST_EXEC;
            ST_EXEC: if (exec_last) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_CLEAR;
            data_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            ops_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
                cnt_q  <= cmd_count;
            end else if (in_exec && (op_q == OP_ADDN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (exec_clear)
                ovf_q <= 1'b0;
            else if (acc_add && sum[ACC_W])
                ovf_q <= 1'b1;
            if (rsp_fire)
                ops_q <= ops_q + 1'b1;
        end
    end

    assign exec_clear = in_exec && (op_q == OP_CLEAR);

    // Strobes are suppressed during reset except clear, which holds the accumulator at zero.
    assign acc_clear = rst | exec_clear;
    assign acc_load  = in_exec && (op_q == OP_LOAD);
    assign acc_add   = in_exec && ((op_q == OP_ADD) || ((op_q == OP_ADDN) && (cnt_q != '0)));
    assign acc_din   = rst ? '0 : data_q;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign rsp_valid = (state == ST_RESP) && !rst;
    assign rsp_data  = acc_result;
    assign rsp_ovf   = ovf_q;
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural accumulator, directed vector table,
// randomized ops against an arithmetic reference, stall and mid-op reset sequences.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = '0;
    logic [7:0]  cmd_count = '0;
    logic        acc_clear, acc_load, acc_add;
    logic [15:0] acc_din;
    logic [31:0] acc_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic [15:0] ops_done;

    logic        preset_en = 1'b0;
    logic [31:0] preset_val = '0;
    logic [31:0] acc_reg = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_acc = '0;
    logic        ref_ovf = 1'b0;
    logic [15:0] exp_ops = '0;

    calc_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_count(cmd_count),
        .acc_clear(acc_clear), .acc_load(acc_load), .acc_add(acc_add),
        .acc_din(acc_din), .acc_result(acc_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator datapath; preset lets the bench place it at an arbitrary value.
    always @(posedge clk) begin
        if (preset_en)      acc_reg <= preset_val;
        else if (acc_clear) acc_reg <= '0;
        else if (acc_load)  acc_reg <= {acc_reg[31:16], acc_din};
        else if (acc_add)   acc_reg <= acc_reg + {16'h0, acc_din};
    end
    assign acc_result = acc_reg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result of an op computed from plain arithmetic on the accumulator value.
    task automatic ref_step(input logic [1:0] op, input logic [15:0] d, input logic [7:0] n);
        logic [63:0] total;
        case (op)
            OP_CLEAR: begin ref_acc = '0; ref_ovf = 1'b0; end
            OP_LOAD:  ref_acc = {ref_acc[31:16], d};
            default: begin
                total = 64'(ref_acc) + ((op == OP_ADD) ? 64'(d) : 64'(n) * 64'(d));
                if (total >= 64'h1_0000_0000) ref_ovf = 1'b1;
                ref_acc = total[31:0];
            end
        endcase
    endtask

    task automatic preset(input logic [31:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
        ref_acc    = v;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] d,
                          input logic [7:0] n, input int hold,
                          input logic [31:0] exp_d, input logic exp_o);
        int waitc, k, nclr, nld, nadd, exp_lat;
        bit multi, got;
        logic [31:0] held;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin tick(); waitc++; end
        check({name, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = n;
        tick();
        cmd_valid = 1'b0; cmd_op = $urandom_range(3, 0); cmd_data = 16'($urandom); cmd_count = 8'($urandom);
        nclr = 0; nld = 0; nadd = 0; multi = 0; got = 0; k = 1;
        while (k <= 300) begin
            nclr += int'(acc_clear); nld += int'(acc_load); nadd += int'(acc_add);
            if (int'(acc_clear) + int'(acc_load) + int'(acc_add) > 1) multi = 1;
            if (rsp_valid) begin got = 1; break; end
            tick();
            k++;
        end
        check({name, " rsp_seen"}, 64'(got), 64'd1);
        if (!got) return;
        exp_lat = (op == OP_ADDN && n != 0) ? int'(n) + 1 : 2;
        check({name, " latency"}, 64'(k), 64'(exp_lat));
        check({name, " n_clear"}, 64'(nclr), 64'(op == OP_CLEAR));
        check({name, " n_load"}, 64'(nld), 64'(op == OP_LOAD));
        check({name, " n_add"}, 64'(nadd), (op == OP_ADD) ? 64'd1 : (op == OP_ADDN) ? 64'(n) : 64'd0);
        check({name, " one_strobe"}, 64'(multi), 64'd0);
        check({name, " rsp_data"}, 64'(rsp_data), 64'(exp_d));
        check({name, " rsp_ovf"}, 64'(rsp_ovf), 64'(exp_o));
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = OP_CLEAR;
            tick();
            check({name, " stall_valid"}, 64'(rsp_valid), 64'd1);
            check({name, " stall_data"}, 64'(rsp_data), 64'(held));
            check({name, " stall_ready"}, 64'(cmd_ready), 64'd0);
            check({name, " stall_strobes"}, 64'({acc_clear, acc_load, acc_add}), 64'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops++;
        check({name, " ops_done"}, 64'(ops_done), 64'(exp_ops));
        check({name, " idle_after"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    typedef struct {
        bit          pre;
        logic [31:0] pre_val;
        logic [1:0]  op;
        logic [15:0] d;
        logic [7:0]  n;
        int          hold;
        logic [31:0] exp_d;
        logic        exp_o;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 32'h0,        OP_LOAD,  16'h1234, 8'd0, 0, 32'h0000_1234, 1'b0};
        vecs[1]  = '{0, 32'h0,        OP_ADD,   16'h0010, 8'd0, 4, 32'h0000_1244, 1'b0};
        vecs[2]  = '{1, 32'h0001_0000, OP_LOAD, 16'hABCD, 8'd0, 0, 32'h0001_ABCD, 1'b0};
        vecs[3]  = '{0, 32'h0,        OP_CLEAR, 16'h0000, 8'd0, 0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{0, 32'h0,        OP_ADDN,  16'h0100, 8'd5, 1, 32'h0000_0500, 1'b0};
        vecs[5]  = '{0, 32'h0,        OP_ADDN,  16'h7777, 8'd0, 0, 32'h0000_0500, 1'b0};
        vecs[6]  = '{1, 32'hFFFF_FFF0, OP_ADD,  16'h0020, 8'd0, 0, 32'h0000_0010, 1'b1};
        vecs[7]  = '{0, 32'h0,        OP_ADD,   16'h0001, 8'd0, 2, 32'h0000_0011, 1'b1};
        vecs[8]  = '{0, 32'h0,        OP_ADDN,  16'h0001, 8'd3, 0, 32'h0000_0014, 1'b1};
        vecs[9]  = '{0, 32'h0,        OP_LOAD,  16'h5555, 8'd0, 0, 32'h0000_5555, 1'b1};
        vecs[10] = '{0, 32'h0,        OP_CLEAR, 16'h0000, 8'd0, 0, 32'h0000_0000, 1'b0};

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst acc_clear", 64'(acc_clear), 64'd1);
            check("rst outputs", 64'({rsp_valid, cmd_ready, acc_load, acc_add}), 64'd0);
            check("rst ops_done", 64'(ops_done), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst acc_result", 64'(acc_result), 64'd0);
        check("post_rst rsp_ovf", 64'(rsp_ovf), 64'd0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].pre) preset(vecs[i].pre_val);
            ref_step(vecs[i].op, vecs[i].d, vecs[i].n);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].n, vecs[i].hold,
                   vecs[i].exp_d, vecs[i].exp_o);
        end

        // Randomized ops; occasional presets near the top of the range exercise carry.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [15:0] d;
            logic [7:0]  n;
            if ($urandom_range(7, 0) == 0) preset(32'hFFF0_0000 | 32'($urandom_range(32'hFFFFF, 0)));
            op = 2'($urandom_range(3, 0));
            if (op == OP_CLEAR && $urandom_range(1, 0) == 1) op = OP_ADD;
            d  = 16'($urandom);
            n  = 8'($urandom_range(12, 0));
            ref_step(op, d, n);
            run_op($sformatf("rnd%0d", i), op, d, n, $urandom_range(2, 0), ref_acc, ref_ovf);
        end

        // Reset in the middle of a long ADDN.
        cmd_valid = 1'b1; cmd_op = OP_ADDN; cmd_data = 16'h0003; cmd_count = 8'd200;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("addn200 running", 64'(acc_add), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst strobes", 64'({acc_clear, acc_load, acc_add}), 64'b100);
        rst = 1'b0;
        tick();
        check("midrst idle", 64'({cmd_ready, rsp_valid, acc_add}), 64'b100);
        check("midrst ops_done", 64'(ops_done), 64'd0);
        check("midrst acc", 64'(acc_result), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst quiet", 64'({acc_clear, acc_load, acc_add, rsp_valid}), 64'd0);
        end
        ref_acc = '0; ref_ovf = 1'b0; exp_ops = '0;
        ref_step(OP_LOAD, 16'h00AB, 8'd0);
        run_op("recover", OP_LOAD, 16'h00AB, 8'd0, 0, 32'h0000_00AB, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
